mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the maximum cycles spent in WAIT before a timeout error.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-004 req  input  1  load/store request from control unit; sampled in IDLE only.
REQ-005 op3  input  6  SPARC op3 of the load/store.
REQ-006 addr  input  32  effective address.
REQ-007 wdata  input  32  store data, right-justified.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse on successful completion.
REQ-010 err  output  1  one-cycle pulse on illegal op3, misalignment or timeout.
REQ-011 err_code  output  2  01 illegal op3, 10 misaligned, 11 timeout; held until next accepted req.
REQ-012 rdata  output  32  load result register (MDR), held until next successful load.
REQ-013 mem_mov, mem_rw (1=read), mem_sign  output  1 each  RAM strobe, direction, sign-extend.
REQ-014 mem_size  output  2  00 byte, 01 halfword, 10 word.
REQ-015 mem_address, mem_data_out  output  32 each  registered RAM address and store data.
REQ-016 mem_moc  input  1  RAM completion; mem_data_in  input  32  RAM read data.

Function
REQ-017 Decode SHALL be: 001001 LDSB, 001010 LDSH, 000001 LDUB, 000010 LDUH, 000000 LD, 000101 STB, 000110 STH, 000100 ST; sign=1 only for LDSB/LDSH; mem_rw=1 for loads, 0 for stores.
REQ-018 Any other op3 SHALL be illegal: no RAM access, err pulse, err_code=01.
REQ-019 States SHALL be IDLE, ISSUE, WAIT, RELEASE, FINISH.
REQ-020 IDLE: on req=1 with legal, aligned op SHALL register op, address, data, size, sign, rw and go to ISSUE next edge.
REQ-021 ISSUE: mem_mov SHALL assert for one cycle before WAIT; address/size/rw/sign/data stable from ISSUE through RELEASE.
REQ-022 WAIT: mem_mov held high; timeout counter increments each cycle; on mem_moc=1 loads SHALL capture mem_data_in into rdata on that edge and go to RELEASE.
REQ-023 RELEASE: mem_mov SHALL be low; stay until mem_moc=0, then FINISH.
REQ-024 FINISH: done SHALL pulse one cycle, then IDLE; minimum request-to-done latency 4 cycles when mem_moc rises first cycle of WAIT and falls in first cycle of RELEASE.
REQ-025 Counter reaching TIMEOUT in WAIT SHALL drop mem_mov, pulse err with err_code=11, return to IDLE; rdata unchanged.
REQ-026 req while busy SHALL be ignored (no queuing).
REQ-027 done and err SHALL never assert in the same cycle.
REQ-028 Address width 32 bits passes unchanged; no wrap or truncation in this block.

Reset
REQ-029 On reset all outputs SHALL be 0 on the next edge: busy, done, err, err_code, rdata, mem_mov, mem_rw, mem_sign, mem_size, mem_address, mem_data_out; state IDLE, counter 0.
REQ-030 Reset mid-transaction SHALL abort it: mem_mov low next edge, no done/err pulse, rdata cleared.

Configuration
REQ-031 With MEM_ALIGN_CHECK_EN defined, halfword with addr[0]=1 or word with addr[1:0]!=00 SHALL be rejected in IDLE: err pulse, err_code=10, no RAM access.
REQ-032 Without MEM_ALIGN_CHECK_EN, no alignment check exists; any address SHALL be issued to RAM and err_code=10 is never produced.

Verification
REQ-033 LD, addr=0x10, RAM returns 0x12345678 with moc one cycle after mov -> mem_size=10, mem_rw=1, done pulse, rdata=0x12345678.
REQ-034 LDSB addr=0x03 -> mem_size=00, mem_sign=1; STH addr=0x20 wdata=0x0000BEEF -> mem_rw=0, mem_size=01, mem_data_out=0x0000BEEF, done, rdata unchanged.
REQ-035 op3=111111 with req -> err pulse, err_code=01, mem_mov never asserts.
REQ-036 mem_moc held 0 -> after 64 WAIT cycles err pulse, err_code=11, mem_mov low, busy low.
REQ-037 LD addr=0x02 -> with MEM_ALIGN_CHECK_EN err_code=10 and no mem_mov; without it access issued and done pulses.
REQ-038 reset asserted in WAIT, second req during busy -> mem_mov low next edge, all outputs 0, no done; extra req ignored.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store access sequencer between the control unit and an asynchronous RAM (mov/moc handshake).
// Optional MEM_ALIGN_CHECK_EN rejects misaligned halfword/word requests before any RAM access.
module mem_access_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [5:0]  op3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] rdata,
  output logic        mem_mov,
  output logic        mem_rw,
  output logic        mem_sign,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  input  logic        mem_moc,
  input  logic [31:0] mem_data_in
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RELEASE, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mov_q, mov_d, rw_q, rw_d, sign_q, sign_d;
  logic [1:0]         size_q, size_d;
  logic [31:0]        address_q, address_d, data_out_q, data_out_d;

  logic               dec_legal, dec_rw, dec_sign, misalign;
  logic [1:0]         dec_size;

  // Returns {legal, rw, sign, size[1:0]}.
  function automatic logic [4:0] decode_op(input logic [5:0] op);
    case (op)
      6'b001001: decode_op = {1'b1, 1'b1, 1'b1, 2'b00}; // LDSB
      6'b001010: decode_op = {1'b1, 1'b1, 1'b1, 2'b01}; // LDSH
      6'b000001: decode_op = {1'b1, 1'b1, 1'b0, 2'b00}; // LDUB
      6'b000010: decode_op = {1'b1, 1'b1, 1'b0, 2'b01}; // LDUH
      6'b000000: decode_op = {1'b1, 1'b1, 1'b0, 2'b10}; // LD
      6'b000101: decode_op = {1'b1, 1'b0, 1'b0, 2'b00}; // STB
      6'b000110: decode_op = {1'b1, 1'b0, 1'b0, 2'b01}; // STH
      6'b000100: decode_op = {1'b1, 1'b0, 1'b0, 2'b10}; // ST
      default:   decode_op = 5'b0;
    endcase
  endfunction

  always_comb begin
    {dec_legal, dec_rw, dec_sign, dec_size} = decode_op(op3);
    misalign = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign = ((dec_size == 2'b01) && addr[0]) ||
               ((dec_size == 2'b10) && (addr[1:0] != 2'b00));
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    rdata_d    = rdata_q;
    mov_d      = mov_q;
    rw_d       = rw_q;
    sign_d     = sign_q;
    size_d     = size_q;
    address_d  = address_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        mov_d = 1'b0;
        if (req) begin
          if (!dec_legal) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else if (misalign) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else begin
            state_d    = ISSUE;
            mov_d      = 1'b1;
            cnt_d      = '0;
            err_code_d = 2'b00;
            rw_d       = dec_rw;
            sign_d     = dec_sign;
            size_d     = dec_size;
            address_d  = addr;
            data_out_d = wdata;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (mem_moc) begin
          if (rw_q) rdata_d = mem_data_in;
          mov_d   = 1'b0;
          state_d = RELEASE;
        end else if ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
          mov_d      = 1'b0;
          err_d      = 1'b1;
          err_code_d = 2'b11;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!mem_moc) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      rdata_q    <= '0;
      mov_q      <= 1'b0;
      rw_q       <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= 2'b00;
      address_q  <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      rdata_q    <= rdata_d;
      mov_q      <= mov_d;
      rw_q       <= rw_d;
      sign_q     <= sign_d;
      size_q     <= size_d;
      address_q  <= address_d;
      data_out_q <= data_out_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign rdata        = rdata_q;
  assign mem_mov      = mov_q;
  assign mem_rw       = rw_q;
  assign mem_sign     = sign_q;
  assign mem_size     = size_q;
  assign mem_address  = address_q;
  assign mem_data_out = data_out_q;

endmodule
